// File: rtl/timer_bcd_display_pkg.sv
// Shared types and constants for the timer BCD display converter.
package timer_bcd_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Active-low gfedcba segment patterns
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/timer_bcd_display_seg7.sv
// One-digit BCD to active-low seven-segment encoder with blanking.
module seg7_encode
    import timer_bcd_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Map the digit to its segment pattern; codes above 9 show dark
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/timer_bcd_display.sv
// Binary millisecond count to packed BCD and seven-segment display,
// using a serial double-dabble converter (one bit per clock).
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | ready high, waiting for valid
// ST_SHIFT | double-dabble in progress, W shift cycles
// ST_DONE  | result just loaded onto bcd/hex, done pulse visible
module timer_bcd_display
    import timer_bcd_display_pkg::*;
#(
    parameter  int MAX_MS = 2000,
    parameter  int DIGITS = 4,
    localparam int W      = $clog2(MAX_MS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          value,
    input  logic                  valid,
    input  logic                  lzb,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int CW      = $clog2(W + 1);
    localparam int MAX_DEC = 10**DIGITS - 1;

    state_t                state;
    logic [W-1:0]          bin_q;
    logic [4*DIGITS-1:0]   work_q;
    logic [CW-1:0]         cnt_q;
    logic                  lzb_q;

    logic [W-1:0]          value_sat;
    logic [4*DIGITS-1:0]   work_next;
    logic [3:0]            nib;
    logic                  carry;
    logic [DIGITS-1:0]     blank;
    logic                  run;
    logic [7*DIGITS-1:0]   hex_next;

    // Inputs that cannot be shown in DIGITS decimal digits become all nines
    always_comb begin
        value_sat = value;
        if (32'(value) > 32'(MAX_DEC)) begin
            value_sat = W'(MAX_DEC);
        end
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next MSB
    always_comb begin
        work_next = '0;
        nib       = '0;
        carry     = bin_q[W-1];
        for (int i = 0; i < DIGITS; i++) begin
            nib = work_q[4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            work_next[4*i +: 4] = {nib[2:0], carry};
            carry = nib[3];
        end
    end

    // Leading-zero blanking from the top digit down; digit 0 always shows
    always_comb begin
        blank = '0;
        run   = lzb_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (work_next[4*i +: 4] != 4'd0) begin
                run = 1'b0;
            end
            blank[i] = run;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_encode u_seg (
            .bcd   (work_next[4*g +: 4]),
            .blank (blank[g]),
            .seg   (hex_next[7*g +: 7])
        );
    end

    // Control FSM with registered ready/done and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            bcd    <= '0;
            hex    <= {DIGITS{SEG_0}};
            bin_q  <= '0;
            work_q <= '0;
            cnt_q  <= '0;
            lzb_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid && ready) begin
                        bin_q  <= value_sat;
                        work_q <= '0;
                        cnt_q  <= CW'(W - 1);
                        lzb_q  <= lzb;
                        ready  <= 1'b0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bin_q  <= bin_q << 1;
                    work_q <= work_next;
                    // The last shift lands straight on the outputs so done
                    // coincides with the first cycle the result is visible.
                    if (cnt_q == '0) begin
                        bcd   <= work_next;
                        hex   <= hex_next;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/timer_bcd_display.md
TIMER_BCD_DISPLAY -- requirements
Module: timer_bcd_display

Interface
REQ-001 Parameter MAX_MS, default 2000, sets the largest timer count and fixes W = $clog2(MAX_MS).
REQ-002 Parameter DIGITS, default 4, sets the number of decimal digits converted and displayed.
REQ-003 Port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Port value, input, W, binary millisecond count taken from the upstream timer's timer_value.
REQ-006 Port valid, input, 1, high when value is to be converted.
REQ-007 Port lzb, input, 1, leading-zero blank request, sampled only with value.
REQ-008 Port ready, output, 1, high when a new value can be accepted.
REQ-009 Port done, output, 1, one-cycle pulse when a new result is loaded onto bcd and hex.
REQ-010 Port bcd, output, 4*DIGITS, packed BCD result, digit 0 in bits [3:0].
REQ-011 Port hex, output, 7*DIGITS, active-low gfedcba segments, digit 0 in bits [6:0].

Function
REQ-012 States SHALL be IDLE, SHIFT and DONE.
REQ-013 ready SHALL be high only in IDLE.
REQ-014 Acceptance SHALL occur on a rising edge where valid and ready are both high; value and lzb are captured, and the state goes to SHIFT.
REQ-015 SHIFT SHALL run a double-dabble: per cycle, add 3 to each BCD nibble >= 5, then shift left one bit with the next binary MSB; exactly W cycles, then DONE.
REQ-016 The converter SHALL have latency W+1: done is high in the W+1-th cycle after the acceptance edge, and ready goes high in the following cycle.
REQ-017 In DONE, bcd and hex SHALL be updated from the completed conversion, done SHALL be high for exactly that one cycle, and the next state SHALL be IDLE.
REQ-018 bcd and hex SHALL hold the previous result from acceptance until DONE.
REQ-019 Captured values above 10^DIGITS-1 SHALL saturate to all nines.
REQ-020 Values at or above MAX_MS SHALL be converted as given, with no clamping to MAX_MS.
REQ-021 Each displayed digit SHALL use the standard active-low encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 When the captured lzb is 1, every zero digit more significant than the highest non-zero digit SHALL show 1111111.
REQ-023 Digit 0 SHALL never be blanked.
REQ-024 valid asserted outside IDLE SHALL be ignored, with no queuing.
REQ-025 If valid is held high continuously, the next acceptance SHALL occur on the edge immediately after the DONE cycle.

Reset
REQ-026 While reset is low, the state SHALL be IDLE, ready SHALL be 1 and done SHALL be 0.
REQ-027 While reset is low, bcd SHALL be 0 and every hex digit SHALL show "0" (1000000).
REQ-028 Reset asserted mid-conversion SHALL abandon the conversion without producing a done pulse.
REQ-029 The first edge after reset release SHALL be able to accept.

Structure
REQ-030 A shared package SHALL hold the state enum, the per-digit segment constants and the blank constant.
REQ-031 A combinational sub-module seg7_encode (4-bit BCD plus blank in, 7-bit segments out) SHALL be instantiated once per digit.

Verification
REQ-032 Basic conversion: reset, then value=1234, lzb=0, one-cycle valid -> done exactly 12 cycles after the acceptance edge; bcd=16'h1234; hex digits 3..0 = 1111001, 0100100, 0110000, 0011001.
REQ-033 Blanking: value=0, lzb=1 -> digit 0 = 1000000, digits 1-3 = 1111111. Then value=1999, lzb=1 -> bcd=16'h1999, no digit blanked.
REQ-034 Back-to-back: valid held high with value=2047 then 5 -> two done pulses 13 cycles apart; final bcd=16'h0005; done is never high for two consecutive cycles.
REQ-035 Reset mid-conversion: reset pulled low 5 cycles after accepting 1500 -> bcd=0, no done, ready=1. After release, 42 -> bcd=16'h0042.
REQ-036 Saturation: MAX_MS=20000, W=15, value=12345 -> bcd=16'h9999, done exactly 16 cycles after the acceptance edge.
REQ-037 Ignored input: change value and pulse valid during SHIFT -> result equals the originally accepted value.
